rf_wb_arbiter: RTL and testbench

Write-back arbiter for the 32x32 register file. Two writers compete for the register file's single write port: requester 0 carries ALU results and requester 1 carries load and multi-cycle results. The arbiter buffers one write per requester, picks one write per cycle, and drives the register file's `we`/`wa_i`/`wd_i` from a registered output stage. It also exports a pending-write bitmap for hazard detection and a saturating conflict counter.

---
 rtl/rf_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the 32x32 register file.
// Two requesters (0: ALU results, 1: load / multi-cycle results) each own a
// one-entry buffer. One buffered write per cycle is granted and moved to a
// registered output stage that drives the register-file write port.
// Optional feature macro: RF_WB_ARB_ROUND_ROBIN_EN. When it is defined, ties
// between different addresses alternate between the requesters. When it is
// undefined, requester 0 always wins those ties.
//
// Handshake (both requesters): a write transfers on a posedge where
// valid_k_i & ready_k_o. ready_k_o depends only on registered state, so there
// is no combinational path from valid_k_i to ready_k_o. A write to $0 is
// accepted and then dropped.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid0_i,
  input  logic [4:0]  wa0_i,
  input  logic [31:0] wd0_i,
  output logic        ready0_o,
  input  logic        valid1_i,
  input  logic [4:0]  wa1_i,
  input  logic [31:0] wd1_i,
  output logic        ready1_o,
  output logic        we_o,
  output logic [4:0]  wa_o,
  output logic [31:0] wd_o,
  output logic [31:0] pend_o,
  output logic [15:0] conflict_cnt_o
);

  logic        occ0, occ1;
  logic [4:0]  buf_wa0, buf_wa1;
  logic [31:0] buf_wd0, buf_wd1;
  logic        age1;      // 1: buffer 1 holds the older entry
  logic        gnt0, gnt1;
  logic        both;
  logic        load0, load1;
  logic        keep1;
  logic [31:0] pend_v;
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
  logic        rr_ptr;    // 1: requester 1 wins the next different-address tie
`endif

  assign both = occ0 & occ1;

  // Grant selection from registered state only.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (both) begin
      if (buf_wa0 == buf_wa1) begin
        gnt1 = age1;
        gnt0 = ~age1;
      end else begin
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
        gnt1 = rr_ptr;
        gnt0 = ~rr_ptr;
`else
        gnt0 = 1'b1;
`endif
      end
    end else begin
      gnt0 = occ0;
      gnt1 = occ1;
    end
  end

  assign ready0_o = ~occ0 | gnt0;
  assign ready1_o = ~occ1 | gnt1;
  assign load0    = valid0_i & ready0_o & (wa0_i != 5'd0);
  assign load1    = valid1_i & ready1_o & (wa1_i != 5'd0);
  assign keep1    = occ1 & ~gnt1;

  // Buffer 0: a new write replaces a draining entry on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ0    <= 1'b0;
      buf_wa0 <= 5'd0;
      buf_wd0 <= 32'd0;
    end else if (load0) begin
      occ0    <= 1'b1;
      buf_wa0 <= wa0_i;
      buf_wd0 <= wd0_i;
    end else if (gnt0) begin
      occ0    <= 1'b0;
    end
  end

  // Buffer 1: same behaviour as buffer 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ1    <= 1'b0;
      buf_wa1 <= 5'd0;
      buf_wd1 <= 32'd0;
    end else if (load1) begin
      occ1    <= 1'b1;
      buf_wa1 <= wa1_i;
      buf_wd1 <= wd1_i;
    end else if (gnt1) begin
      occ1    <= 1'b0;
    end
  end

  // Age bit: buffer 1 is older only if buffer 0 was loaded while buffer 1
  // stayed occupied. When both are loaded on the same edge, buffer 0 counts as
  // older.
  always_ff @(posedge clk) begin
    if (rst) begin
      age1 <= 1'b0;
    end else if (load0 | load1) begin
      age1 <= load0 & ~load1 & keep1;
    end
  end

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: after a contended cycle, the loser gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (both) begin
      rr_ptr <= gnt0;
    end
  end
`endif

  // Output stage: commit the granted entry. The address and data hold when
  // there is no grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_o <= 1'b0;
      wa_o <= 5'd0;
      wd_o <= 32'd0;
    end else if (gnt0) begin
      we_o <= 1'b1;
      wa_o <= buf_wa0;
      wd_o <= buf_wd0;
    end else if (gnt1) begin
      we_o <= 1'b1;
      wa_o <= buf_wa1;
      wd_o <= buf_wd1;
    end else begin
      we_o <= 1'b0;
    end
  end

  // Saturating count of cycles with both buffers occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= 16'd0;
    end else if (both && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end

  // Pending-write bitmap over both buffers and the output stage.
  always_comb begin
    pend_v = 32'd0;
    if (occ0) pend_v[buf_wa0] = 1'b1;
    if (occ1) pend_v[buf_wa1] = 1'b1;
    if (we_o) pend_v[wa_o]    = 1'b1;
    pend_v[0] = 1'b0;
  end

  assign pend_o = pend_v;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. The reference model keeps each
// buffered write with a load timestamp and applies the arbitration rules
// directly. A scoreboard compares the DUT with the model every cycle. The
// scenario tasks also check the specific values their scenario requires.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        ready0, ready1;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pend;
  logic [15:0] cnt;

  int vectors = 0;
  int miscompares = 0;
  bit sb_en = 1'b0;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .valid0_i(valid0), .wa0_i(wa0), .wd0_i(wd0), .ready0_o(ready0),
    .valid1_i(valid1), .wa1_i(wa1), .wd1_i(wd1), .ready1_o(ready1),
    .we_o(we), .wa_o(wa), .wd_o(wd), .pend_o(pend), .conflict_cnt_o(cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Register file fed by the DUT. It captures on the negedge.
  logic [31:0] rf_dut [32];
  always @(negedge clk) if (we === 1'b1) rf_dut[wa] <= wd;

  // ---------------- reference model ----------------
  bit          m_occ [2];
  logic [4:0]  m_a   [2];
  logic [31:0] m_d   [2];
  int          m_t   [2];
  int          m_last;      // requester that won the last contended grant
  int          m_cyc;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_cnt;
  logic [31:0] rf_model [32];
  logic [36:0] exp_q [$];

  function automatic int m_winner();
    if (m_occ[0] && m_occ[1]) begin
      if (m_a[0] == m_a[1]) return (m_t[1] < m_t[0]) ? 1 : 0;
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (m_occ[0]) return 0;
    if (m_occ[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = 32'd0;
    for (int k = 0; k < 2; k++) if (m_occ[k]) p[m_a[k]] = 1'b1;
    if (m_we) p[m_wa] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(posedge clk) begin
    int w;
    bit r0, r1;
    if (rst) begin
      m_occ[0] = 0; m_occ[1] = 0;
      m_last = 1;              // requester 0 wins the first contended tie
      m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_cnt = 0;
      exp_q.delete();
    end else begin
      w  = m_winner();
      r0 = !m_occ[0] || (w == 0);
      r1 = !m_occ[1] || (w == 1);
      if (m_occ[0] && m_occ[1]) begin
        m_last = w;
        if (m_cnt < 65535) m_cnt++;
      end
      if (w >= 0) begin
        m_we = 1'b1; m_wa = m_a[w]; m_wd = m_d[w];
        rf_model[m_wa] = m_wd;
        exp_q.push_back({m_wa, m_wd});
        m_occ[w] = 0;
      end else begin
        m_we = 1'b0;
      end
      if (valid0 && r0 && wa0 != 5'd0) begin
        m_occ[0] = 1; m_a[0] = wa0; m_d[0] = wd0; m_t[0] = m_cyc;
      end
      if (valid1 && r1 && wa1 != 5'd0) begin
        m_occ[1] = 1; m_a[1] = wa1; m_d[1] = wd1; m_t[1] = m_cyc;
      end
    end
    m_cyc++;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    int w;
    logic [36:0] e;
    if (sb_en) begin
      w = m_winner();
      vectors++;
      if (ready0 !== (!m_occ[0] || w == 0)) begin
        miscompares++; $display("FAIL sb_ready0 t=%0t got %b want %b", $time, ready0, (!m_occ[0] || w == 0));
      end
      vectors++;
      if (ready1 !== (!m_occ[1] || w == 1)) begin
        miscompares++; $display("FAIL sb_ready1 t=%0t got %b want %b", $time, ready1, (!m_occ[1] || w == 1));
      end
      vectors++;
      if (we !== m_we) begin
        miscompares++; $display("FAIL sb_we t=%0t got %b want %b", $time, we, m_we);
      end
      if (we === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL sb_commit t=%0t got wa=%0d wd=%h want no commit", $time, wa, wd);
        end else begin
          e = exp_q.pop_front();
          if ({wa, wd} !== e) begin
            miscompares++; $display("FAIL sb_commit t=%0t got wa=%0d wd=%h want wa=%0d wd=%h", $time, wa, wd, e[36:32], e[31:0]);
          end
        end
      end
      vectors++;
      if (pend !== m_pend()) begin
        miscompares++; $display("FAIL sb_pend t=%0t got %h want %h", $time, pend, m_pend());
      end
      vectors++;
      if (cnt !== m_cnt[15:0]) begin
        miscompares++; $display("FAIL sb_cnt t=%0t got %0d want %0d", $time, cnt, m_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid0 = 1'b0; valid1 = 1'b0;
    wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    sb_en = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({we, pend, cnt, ready0, ready1} !== {1'b0, 32'd0, 16'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state got we=%b pend=%h cnt=%0d rdy=%b%b want we=0 pend=0 cnt=0 rdy=11", we, pend, cnt, ready0, ready1);
    end
  endtask

  task automatic test_single();
    valid0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    vectors++;
    if (ready0 !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b want 1", ready0); end
    tick();
    idle_inputs();
    vectors++;
    if (we !== 1'b0 || pend[5] !== 1'b1) begin
      miscompares++; $display("FAIL single_buffered got we=%b pend5=%b want we=0 pend5=1", we, pend[5]);
    end
    tick();
    vectors++;
    if ({we, wa, wd} !== {1'b1, 5'd5, 32'hDEADBEEF} || pend[5] !== 1'b1) begin
      miscompares++; $display("FAIL single_commit got we=%b wa=%0d wd=%h pend5=%b want 1 5 deadbeef 1", we, wa, wd, pend[5]);
    end
    tick();
    vectors++;
    if (we !== 1'b0 || pend !== 32'd0) begin
      miscompares++; $display("FAIL single_done got we=%b pend=%h want we=0 pend=0", we, pend);
    end
    vectors++;
    if (rf_dut[5] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL single_rf got %h want deadbeef", rf_dut[5]);
    end
  endtask

  task automatic test_zero_write();
    valid1 = 1'b1; wa1 = 5'd0; wd1 = 32'h12345678;
    vectors++;
    if (ready1 !== 1'b1) begin miscompares++; $display("FAIL zero_ready got %b want 1", ready1); end
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (we !== 1'b0 || pend !== 32'd0) begin
        miscompares++; $display("FAIL zero_drop got we=%b pend=%h want we=0 pend=0", we, pend);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [4:0] seq [$];
    logic [4:0] want [4];
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    want = '{5'd3, 5'd4, 5'd3, 5'd4};
`else
    want = '{5'd3, 5'd3, 5'd3, 5'd3};
`endif
    apply_reset();
    valid0 = 1'b1; wa0 = 5'd3; valid1 = 1'b1; wa1 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      wd0 = 32'h3000 + i; wd1 = 32'h4000 + i;
      tick();
      if (we === 1'b1) seq.push_back(wa);
    end
    idle_inputs();
    vectors++;
    if (cnt !== 16'd3) begin miscompares++; $display("FAIL contend_cnt got %0d want 3", cnt); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (we === 1'b1) seq.push_back(wa);
    end
    vectors++;
    if (seq.size() != 5) begin
      miscompares++; $display("FAIL contend_count got %0d commits want 5", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (seq[i] !== want[i]) begin
          miscompares++; $display("FAIL contend_order[%0d] got r%0d want r%0d", i, seq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_same_addr();
    apply_reset();
    valid0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA;
    valid1 = 1'b1; wa1 = 5'd7; wd1 = 32'd1;
    tick();
    valid1 = 1'b0;
    wa0 = 5'd7; wd0 = 32'd2;
    vectors++;
    if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
      miscompares++; $display("FAIL same_ready got %b%b want 10", ready0, ready1);
    end
    tick();
    idle_inputs();
    vectors++;
    if ({we, wa} !== {1'b1, 5'd3}) begin miscompares++; $display("FAIL same_first got we=%b wa=%0d want 1 3", we, wa); end
    tick();
    vectors++;
    if ({we, wa, wd} !== {1'b1, 5'd7, 32'd1}) begin
      miscompares++; $display("FAIL same_older got we=%b wa=%0d wd=%0d want 1 7 1", we, wa, wd);
    end
    tick();
    vectors++;
    if ({we, wa, wd} !== {1'b1, 5'd7, 32'd2}) begin
      miscompares++; $display("FAIL same_newer got we=%b wa=%0d wd=%0d want 1 7 2", we, wa, wd);
    end
    tick();
    vectors++;
    if (rf_dut[7] !== 32'd2) begin miscompares++; $display("FAIL same_rf got %0d want 2", rf_dut[7]); end
  endtask

  task automatic test_reset_mid();
    valid0 = 1'b1; wa0 = 5'd10; wd0 = 32'hBAD0;
    valid1 = 1'b1; wa1 = 5'd11; wd1 = 32'hBAD1;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({we, pend, cnt, ready0, ready1} !== {1'b0, 32'd0, 16'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_state got we=%b pend=%h cnt=%0d rdy=%b%b want we=0 pend=0 cnt=0 rdy=11", we, pend, cnt, ready0, ready1);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (we !== 1'b0) begin miscompares++; $display("FAIL midreset_we got %b want 0", we); end
      tick();
    end
    vectors++;
    if (rf_dut[10] !== 32'd0 || rf_dut[11] !== 32'd0) begin
      miscompares++; $display("FAIL midreset_rf got r10=%h r11=%h want 0 0", rf_dut[10], rf_dut[11]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid0 = ($urandom_range(0, 3) != 0);
      valid1 = ($urandom_range(0, 3) != 0);
      wa0 = 5'($urandom_range(0, 7));
      wa1 = 5'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    valid0 = 1'b1; wa0 = 5'd3; valid1 = 1'b1; wa1 = 5'd4;
    for (int i = 0; i < 70000; i++) begin
      wd0 = i; wd1 = ~i;
      tick();
    end
    vectors++;
    if (cnt !== 16'hFFFF) begin miscompares++; $display("FAIL saturation got %h want ffff", cnt); end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_regfile();
    for (int r = 0; r < 32; r++) begin
      vectors++;
      if (rf_dut[r] !== rf_model[r]) begin
        miscompares++; $display("FAIL regfile r%0d got %h want %h", r, rf_dut[r], rf_model[r]);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    for (int r = 0; r < 32; r++) begin
      rf_dut[r] = 32'd0;
      rf_model[r] = 32'd0;
    end
    m_cyc = 0;
    test_reset();
    test_single();
    test_zero_write();
    test_contention();
    test_same_addr();
    test_reset_mid();
    test_random();
    test_saturation();
    test_regfile();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
